// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state type, widths and helpers for the I2S transmit
// controller (i2s_ctrl and its clock-enable dividers).
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_RUN,
      ST_DRAIN
   } i2s_ctrl_state_t;

   localparam int SAMPLE_W          = 48;
   localparam int SCLK_EN_PER_FRAME = 128;
   localparam int FRAME_W           = $clog2(SCLK_EN_PER_FRAME);
   localparam int UNDERRUN_W        = 16;

   function automatic logic [UNDERRUN_W-1:0] sat_inc(
      input logic [UNDERRUN_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/i2s_ctrl_clk_en_div.sv
// clk_en_div: free-running divider producing a registered one-cycle
// strobe every DIV cycles while run is high.
// Ports: clk, rst (async, active-high), clr (restart count), run
//   (count enable), pulse (one-cycle strobe).
module clk_en_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic pulse
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   // First strobe lands DIV cycles after the clearing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (run) begin
         if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            pulse <= 1'b1;
         end else begin
            cnt   <= cnt + 1'b1;
            pulse <= 1'b0;
         end
      end else begin
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/i2s_ctrl.sv
// i2s_ctrl: I2S transmit sequencer. Generates mclk_en/sclk_en strobes,
// arbitrates two stereo sources into a 1-entry holding register and
// runs IDLE/WARMUP/RUN/DRAIN so playback stops on a frame boundary.
// Ports: clk, rst (async, active-high), enable, cnt_clr,
//   src0_*/src1_* (48-bit {left,right} sample with valid/ready),
//   mclk_en, sclk_en, out_data/out_valid/out_ready, active, grant,
//   underrun_cnt.
// Build option I2S_CTRL_HOLD_LAST_EN: on underrun resend the last
//   transferred sample instead of zero.
module i2s_ctrl
   import i2s_pkg::*;
#(
   parameter int MCLK_DIV    = 4,
   parameter int SCLK_DIV    = 16,
   parameter int WARMUP_MCLK = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cnt_clr,
   input  logic [SAMPLE_W-1:0]   src0_data,
   input  logic                  src0_valid,
   output logic                  src0_ready,
   input  logic [SAMPLE_W-1:0]   src1_data,
   input  logic                  src1_valid,
   output logic                  src1_ready,
   output logic                  mclk_en,
   output logic                  sclk_en,
   output logic [SAMPLE_W-1:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  active,
   output logic [1:0]            grant,
   output logic [UNDERRUN_W-1:0] underrun_cnt
);

   localparam int WARM_W = $clog2(WARMUP_MCLK + 1);

   i2s_ctrl_state_t state, next_state;

   logic                enter_warm;
   logic                enter_run;
   logic                enter_idle;
   logic                run_mclk;
   logic                run_sclk;
   logic                clr_sclk;
   logic                warm_last;
   logic                wrap;
   logic                loadable;
   logic                xfer;
   logic                pop;
   logic                underrun;
   logic                full;
   logic [SAMPLE_W-1:0] hold_data;
   logic [SAMPLE_W-1:0] fill_data;
   logic [FRAME_W-1:0]  frame_cnt;
   logic [WARM_W-1:0]   warm_cnt;

   assign warm_last = (warm_cnt == WARM_W'(WARMUP_MCLK - 1));
   assign wrap      = sclk_en &&
                      (frame_cnt == FRAME_W'(SCLK_EN_PER_FRAME - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      active     = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (enable) next_state = ST_WARMUP;
         end
         ST_WARMUP: begin
            active = 1'b1;
            if (!enable)
               next_state = ST_IDLE;
            else if (mclk_en && warm_last)
               next_state = ST_RUN;
         end
         ST_RUN: begin
            active    = 1'b1;
            out_valid = 1'b1;
            if (!enable) next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            active    = 1'b1;
            out_valid = 1'b1;
            if (enable)
               next_state = ST_RUN;
            else if (wrap)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign enter_warm = (state == ST_IDLE) && (next_state == ST_WARMUP);
   assign enter_run  = (state == ST_WARMUP) && (next_state == ST_RUN);
   assign enter_idle = (state != ST_IDLE) && (next_state == ST_IDLE);

   // Gate on the next state so no strobe is ever registered into IDLE.
   assign run_mclk = (next_state != ST_IDLE);
   assign run_sclk = (next_state == ST_RUN) || (next_state == ST_DRAIN);
   assign clr_sclk = enter_warm || enter_run;

   clk_en_div #(.DIV(MCLK_DIV)) u_mclk_div (
      .clk   (clk),
      .rst   (rst),
      .clr   (enter_warm),
      .run   (run_mclk),
      .pulse (mclk_en)
   );

   clk_en_div #(.DIV(SCLK_DIV)) u_sclk_div (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_sclk),
      .run   (run_sclk),
      .pulse (sclk_en)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         warm_cnt <= '0;
      else if (enter_warm)
         warm_cnt <= '0;
      else if ((state == ST_WARMUP) && mclk_en)
         warm_cnt <= warm_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt <= '0;
      else if (enter_idle)
         frame_cnt <= '0;
      else if (sclk_en)
         frame_cnt <= frame_cnt + 1'b1;
   end

   assign loadable   = (state != ST_IDLE) && !full;
   assign src0_ready = loadable;
   assign src1_ready = loadable && !src0_valid;

   assign xfer     = out_valid && out_ready;
   assign pop      = xfer && full;
   assign underrun = xfer && !full;

   // Load and pop never coincide: load needs empty, pop needs full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= 1'b0;
         hold_data <= '0;
         grant     <= 2'b00;
      end else if (enter_idle) begin
         full  <= 1'b0;
         grant <= 2'b00;
      end else if (loadable && src0_valid) begin
         full      <= 1'b1;
         hold_data <= src0_data;
         grant     <= 2'b01;
      end else if (loadable && src1_valid) begin
         full      <= 1'b1;
         hold_data <= src1_data;
         grant     <= 2'b10;
      end else if (pop) begin
         full  <= 1'b0;
         grant <= 2'b00;
      end
   end

`ifdef I2S_CTRL_HOLD_LAST_EN
   logic [SAMPLE_W-1:0] last_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_data <= '0;
      else if (enter_idle)
         last_data <= '0;
      else if (xfer)
         last_data <= out_data;
   end

   assign fill_data = last_data;
`else
   assign fill_data = '0;
`endif

   assign out_data = full ? hold_data : fill_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         underrun_cnt <= '0;
      else if (cnt_clr)
         underrun_cnt <= '0;
      else if (underrun)
         underrun_cnt <= sat_inc(underrun_cnt);
   end

endmodule

// File: tb/tb_i2s_ctrl.sv
// tb_i2s_ctrl: randomized scoreboard bench for i2s_ctrl with a
// cycle-timed reference model of the controller's behaviour.
module tb_i2s_ctrl;

   localparam int MD = 2;
   localparam int SD = 8;
   localparam int WM = 4;

   localparam int P_IDLE  = 0;
   localparam int P_WARM  = 1;
   localparam int P_RUN   = 2;
   localparam int P_DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [47:0] src0_data = '0;
   logic        src0_valid = 1'b0;
   logic [47:0] src1_data = '0;
   logic        src1_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        src0_ready;
   logic        src1_ready;
   logic        mclk_en;
   logic        sclk_en;
   logic [47:0] out_data;
   logic        out_valid;
   logic        active;
   logic [1:0]  grant;
   logic [15:0] underrun_cnt;

   i2s_ctrl #(
      .MCLK_DIV    (MD),
      .SCLK_DIV    (SD),
      .WARMUP_MCLK (WM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .cnt_clr      (cnt_clr),
      .src0_data    (src0_data),
      .src0_valid   (src0_valid),
      .src0_ready   (src0_ready),
      .src1_data    (src1_data),
      .src1_valid   (src1_valid),
      .src1_ready   (src1_ready),
      .mclk_en      (mclk_en),
      .sclk_en      (sclk_en),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .active       (active),
      .grant        (grant),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] d;
      logic [1:0]  g;
   } ent_t;

   ent_t sb[$];

   int checks = 0;
   int failures = 0;

   int          m_ph = P_IDLE;
   int          tm = 0;
   int          tr = 0;
   int          wc = 0;
   int          frame = 0;
   logic [15:0] uc = '0;
   logic [47:0] last = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom()), 32'($urandom())};
   endfunction

   // Reference model + monitor: expectations for the current cycle,
   // then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      logic        mexp;
      logic        sexp;
      logic        ld;
      logic        ov;
      logic        xfer;
      logic        emp;
      logic [47:0] fill;
      logic [47:0] exp_d;
      logic [1:0]  exp_g;
      ent_t        e;
      int          nph;
      if (rst) begin
         m_ph  = P_IDLE;
         tm    = 0;
         tr    = 0;
         wc    = 0;
         frame = 0;
         uc    = '0;
         last  = '0;
         sb.delete();
      end
      mexp = (m_ph != P_IDLE) && (tm > 0) && (tm % MD == 0);
      sexp = ((m_ph == P_RUN) || (m_ph == P_DRAIN)) &&
             (tr > 0) && (tr % SD == 0);
`ifdef I2S_CTRL_HOLD_LAST_EN
      fill = last;
`else
      fill = '0;
`endif
      ov    = (m_ph == P_RUN) || (m_ph == P_DRAIN);
      emp   = (sb.size() == 0);
      ld    = (m_ph != P_IDLE) && emp;
      exp_d = emp ? fill : sb[0].d;
      exp_g = emp ? 2'b00 : sb[0].g;
      chk("mclk_en", 64'(mclk_en), 64'(mexp));
      chk("sclk_en", 64'(sclk_en), 64'(sexp));
      chk("active", 64'(active), 64'(m_ph != P_IDLE));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("src0_ready", 64'(src0_ready), 64'(ld));
      chk("src1_ready", 64'(src1_ready), 64'(ld && !src0_valid));
      chk("grant", 64'(grant), 64'(exp_g));
      chk("out_data", 64'(out_data), 64'(exp_d));
      chk("underrun_cnt", 64'(underrun_cnt), 64'(uc));
      if (!rst) begin
         xfer = ov && out_ready;
         if (xfer) begin
            last = exp_d;
            if (!emp) begin
               e = sb.pop_front();
               chk("sb_pop", 64'(out_data), 64'(e.d));
            end
         end
         if (cnt_clr)
            uc = '0;
         else if (xfer && emp && uc != 16'hFFFF)
            uc = uc + 16'd1;
         if (ld && src0_valid)
            sb.push_back('{d: src0_data, g: 2'b01});
         else if (ld && src1_valid)
            sb.push_back('{d: src1_data, g: 2'b10});
         nph = m_ph;
         case (m_ph)
            P_IDLE:  if (enable) nph = P_WARM;
            P_WARM: begin
               if (!enable) nph = P_IDLE;
               else if (mexp && wc == WM - 1) nph = P_RUN;
            end
            P_RUN:   if (!enable) nph = P_DRAIN;
            default: begin
               if (enable) nph = P_RUN;
               else if (sexp && frame == 127) nph = P_IDLE;
            end
         endcase
         if (m_ph == P_WARM && mexp) wc++;
         if (sexp) frame = (frame + 1) % 128;
         tm++;
         tr++;
         if (m_ph == P_IDLE && nph == P_WARM) begin
            tm = 0;
            wc = 0;
         end
         if (m_ph == P_WARM && nph == P_RUN) tr = 0;
         if (m_ph != P_IDLE && nph == P_IDLE) begin
            sb.delete();
            frame = 0;
            last  = '0;
         end
         m_ph = nph;
      end
   end

   initial begin
      int          n;
      int          k;
      int          ms;
      int          ss;
      logic        ok;
      logic [47:0] a;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 enable = 1'b1;

      // start-up: warm-up strobes, then first sclk_en
      ms = 0;
      ss = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         if (active) begin
            ms += int'(mclk_en);
            ss += int'(sclk_en);
         end
      end
      chk("run_reached", 64'(ok), 64'd1);
      chk("warmup_mclk", 64'(ms), 64'(WM));
      chk("warmup_sclk", 64'(ss), 64'd0);
      k = 0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         k++;
         if (sclk_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("first_sclk_seen", 64'(ok), 64'd1);
      chk("first_sclk_delay", 64'(k), 64'(SD));

      // priority
      @(posedge clk);
      #1;
      a = rnd48();
      src0_data  = a;
      src0_valid = 1'b1;
      src1_data  = 48'h222222_222222;
      src1_valid = 1'b1;
      @(negedge clk);
      chk("prio_src0_ready", 64'(src0_ready), 64'd1);
      chk("prio_src1_ready", 64'(src1_ready), 64'd0);
      @(posedge clk);
      #1 src0_valid = 1'b0;
      @(negedge clk);
      chk("prio_grant0", 64'(grant), 64'd1);
      chk("prio_data0", 64'(out_data), 64'(a));
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (grant == 2'b10) begin
            ok = 1'b1;
            break;
         end
      end
      chk("prio_grant1", 64'(ok), 64'd1);
      chk("prio_data1", 64'(out_data), 64'h222222_222222);
      @(posedge clk);
      #1;
      src1_valid = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      cnt_clr   = 1'b1;

      // underrun x3
      @(posedge clk);
      #1;
      cnt_clr   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("underrun_cnt3", 64'(underrun_cnt), 64'd3);
`ifdef I2S_CTRL_HOLD_LAST_EN
      chk("underrun_fill", 64'(out_data), 64'h222222_222222);

      // hold-last
      @(posedge clk);
      #1;
      src0_valid = 1'b1;
      src0_data  = 48'hABCDEF_123456;
      @(posedge clk);
      #1;
      src0_valid = 1'b0;
      out_ready  = 1'b1;
      cnt_clr    = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("hold_last_data", 64'(out_data), 64'hABCDEF_123456);
      chk("hold_last_cnt", 64'(underrun_cnt), 64'd1);
`else
      chk("underrun_fill", 64'(out_data), 64'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         src0_valid = ($urandom() % 3) == 0;
         src0_data  = rnd48();
         src1_valid = ($urandom() % 2) == 0;
         src1_data  = rnd48();
         out_ready  = ($urandom() % 4) != 0;
         cnt_clr    = ($urandom() % 64) == 0;
         if (($urandom() % 400) == 0) enable = ~enable;
      end
      @(posedge clk);
      #1;
      enable     = 1'b0;
      cnt_clr    = 1'b0;
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!active) begin
            ok = 1'b1;
            break;
         end
      end
      chk("random_to_idle", 64'(ok), 64'd1);

      // drain from frame count 100
      @(posedge clk);
      #1 enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_run", 64'(ok), 64'd1);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sclk_en) n++;
         if (n == 100) break;
      end
      chk("drain_frame100", 64'(n), 64'd100);
      @(posedge clk);
      #1 enable = 1'b0;
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!active) begin
            ok = 1'b1;
            break;
         end
         n += int'(sclk_en);
      end
      chk("drain_idle", 64'(ok), 64'd1);
      chk("drain_pulses", 64'(n), 64'd28);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // saturation
      @(posedge clk);
      #1;
      enable    = 1'b1;
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (underrun_cnt == 16'hFFFF) begin
            ok = 1'b1;
            break;
         end
      end
      chk("sat_reached", 64'(ok), 64'd1);
      repeat (4) @(negedge clk);
      chk("sat_hold", 64'(underrun_cnt), 64'hFFFF);

      // async reset mid-frame
      @(posedge clk);
      #1 src0_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mclk", 64'(mclk_en), 64'd0);
      chk("rst_sclk", 64'(sclk_en), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_active", 64'(active), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_underrun", 64'(underrun_cnt), 64'd0);
      chk("rst_src0_ready", 64'(src0_ready), 64'd0);
      chk("rst_src1_ready", 64'(src1_ready), 64'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      enable     = 1'b0;
      src0_valid = 1'b0;
      out_ready  = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2s_ctrl.md
# i2s_ctrl

Controller that sequences the I2S transmit path: it generates the `mclk_en`/`sclk_en` clock-enable strobes for the I2S master and arbitrates between two stereo sample sources feeding the master's 48-bit sample port. It sits between the sample producers (stream DMA, tone generator) and the I2S master. It runs a start/warm-up/run/drain sequence so that codec clocks are stable before data flows and playback always stops on a frame boundary.

## Interface
- `MCLK_DIV`, default 4: clk cycles per `mclk_en` pulse; range ≥2.
- `SCLK_DIV`, default 16: clk cycles per `sclk_en` pulse; must be an integer multiple of `MCLK_DIV`.
- `WARMUP_MCLK`, default 256: number of `mclk_en` pulses in WARMUP; range ≥1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: playback request (level).
- `cnt_clr` in 1: synchronous clear of `underrun_cnt`.
- `src0_data` in 48: primary sample, {left[23:0], right[23:0]}.
- `src0_valid` in 1 / `src0_ready` out 1: primary source handshake.
- `src1_data` in 48 / `src1_valid` in 1 / `src1_ready` out 1: fallback source.
- `mclk_en` out 1: one-cycle strobe to the I2S master.
- `sclk_en` out 1: one-cycle strobe to the I2S master.
- `out_data` out 48: sample to the I2S master.
- `out_valid` out 1 / `out_ready` in 1: sample handshake toward the I2S master.
- `active` out 1: high in WARMUP, RUN and DRAIN.
- `grant` out 2: one-hot source of the sample currently held; 00 = none.
- `underrun_cnt` out 16: saturating count of fill samples sent.

## Operation
- States: IDLE, WARMUP, RUN, DRAIN.
  - IDLE→WARMUP when `enable`=1.
  - WARMUP→RUN after the `WARMUP_MCLK`-th `mclk_en` pulse.
  - WARMUP→IDLE if `enable` drops.
  - RUN→DRAIN when `enable`=0.
  - DRAIN→RUN if `enable` returns.
  - DRAIN→IDLE on frame wrap.
- Dividers:
  - Both divider counters clear on entering WARMUP.
  - `mclk_en` pulses in WARMUP/RUN/DRAIN. `sclk_en` pulses in RUN/DRAIN only.
  - The first pulse of each comes `*_DIV` cycles after its counter is cleared. The `sclk_en` counter is cleared again on WARMUP→RUN, so the first `sclk_en` is `SCLK_DIV` cycles after entering RUN.
- Frame counter: 7 bits, counts `sclk_en` pulses in RUN/DRAIN (128 per 64-SCLK frame). A wrap is the pulse that takes it from 127 to 0.
- Holding register (1 entry):
  - Loads only when empty at the start of the cycle (no bypass); in WARMUP/RUN/DRAIN.
  - Fixed priority: src0 if `src0_valid`, else src1.
  - `src0_ready` = loadable. `src1_ready` = loadable && !`src0_valid`.
  - `grant` reflects the held source; it clears when the register empties.
- Output:
  - `out_valid`=1 throughout RUN/DRAIN, 0 otherwise.
  - Register full: `out_data` = held sample; the register empties on `out_valid`&&`out_ready`.
  - Register empty: `out_data` = fill sample. The transfer increments `underrun_cnt`, saturating at 0xFFFF.
- `cnt_clr` has priority over an increment in the same cycle.
- Entering IDLE flushes the holding register and resets the frame counter.
- Reset values: all outputs 0, `underrun_cnt`=0, state IDLE, counters 0.

## Timing
- `mclk_en` and `sclk_en` are registered, exactly one cycle wide, and never asserted in IDLE.
- Source-to-holding-register latency: 1 cycle. Holding-register-to-`out_data`: combinational from registers.
- After a transfer there is a 1-cycle bubble before reload. At the default divider settings this bubble never reaches the I2S master.
- Behaviour when `enable` drops:
  - In RUN at frame count k: `sclk_en` continues until the wrap pulse (128−k pulses).
  - The state is IDLE the cycle after the wrap pulse. No `mclk_en`/`sclk_en` after that.
- Async `rst` mid-frame: all outputs 0 immediately. The holding register is lost; sources see `ready`=0.
- `src*_ready` is combinational from the state, the holding-register status and `src0_valid` only. There is no path from `out_ready`.

## Configuration
- `I2S_CTRL_HOLD_LAST_EN`:
  - Defined: the fill sample is the last sample transferred to the I2S master (0 if none since IDLE).
  - Undefined: the fill sample is 48'h0.
  - `underrun_cnt` counts fill samples in both cases.

## Structure
- Package `i2s_pkg`:
  - State enum `i2s_ctrl_state_t`.
  - `SAMPLE_W`=48.
  - `SCLK_EN_PER_FRAME`=128.
  - `UNDERRUN_W`=16.
- Sub-module `clk_en_div`:
  - Parameter `DIV`; inputs `clk`, `rst`, `clr`, `run`; output `pulse`.
  - Instantiated twice, for MCLK and SCLK.

## Test plan
- Start-up: `MCLK_DIV`=2, `SCLK_DIV`=8, `WARMUP_MCLK`=4; `enable`=1 → 4 `mclk_en` pulses, 2 cycles apart, with no `sclk_en`. RUN is entered, then the first `sclk_en` arrives 8 cycles later.
- Priority: `src0_valid`=`src1_valid`=1 with `src1_data`=48'h222222_222222 → src0 accepted, `src1_ready`=0, `grant`=01. Drop src0 → next load from src1, `grant`=10.
- Underrun: no valid sources in RUN, `out_ready` pulsed 3 times → `out_data`=0 (macro off), `underrun_cnt`=3.
- Hold-last: `I2S_CTRL_HOLD_LAST_EN` on, last sample 48'hABCDEF_123456 then an underrun → `out_data`=48'hABCDEF_123456, `underrun_cnt`=1.
- Drain: `enable` deasserted at frame count 100 → exactly 28 more `sclk_en` pulses, then IDLE, `active`=0, `out_valid`=0.
- Saturation and reset: `underrun_cnt` preset to 0xFFFF plus one underrun → stays 0xFFFF. Assert `rst` mid-frame → all outputs 0 in the same cycle.
